// File: rtl/svreal_pair_accum.sv
// svreal_pair_accum: decimating boxcar averager for an svreal (a, b) pair.
// Averages 2**n_log2 aligned samples per stream; one result per block.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   in_a, in_b     : signed input samples (own width/exponent each)
//   in_valid       : input pair valid
//   in_ready       : block accepts a pair (state and rst only)
//   out_a, out_b   : averaged results, common out_width/out_exponent
//   out_valid      : result held until out_ready
//   out_ready      : downstream accepts the result
//
// Build option: define SVREAL_PAIR_ACCUM_SAT_EN to clamp aligned samples
// that leave the out_width range; otherwise they wrap (two's complement).

module svreal_pair_accum #(
   parameter int a_width      = 18,
   parameter int a_exponent   = -10,
   parameter int b_width      = 19,
   parameter int b_exponent   = -11,
   parameter int out_width    = 24,
   parameter int out_exponent = -8,
   parameter int n_log2       = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [a_width-1:0]   in_a,
   input  logic signed [b_width-1:0]   in_b,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic signed [out_width-1:0] out_a,
   output logic signed [out_width-1:0] out_b,
   output logic                        out_valid,
   input  logic                        out_ready
);

   localparam int SA    = a_exponent - out_exponent;
   localparam int A_SHL = (SA > 0) ? SA : 0;
   localparam int A_SHR = (SA < 0) ? -SA : 0;
   localparam int A_XW  = a_width + A_SHL + out_width;

   localparam int SB    = b_exponent - out_exponent;
   localparam int B_SHL = (SB > 0) ? SB : 0;
   localparam int B_SHR = (SB < 0) ? -SB : 0;
   localparam int B_XW  = b_width + B_SHL + out_width;

   localparam int ACC_W = out_width + n_log2;
   localparam int CNT_W = (n_log2 > 0) ? n_log2 : 1;

   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((1 << n_log2) - 1);

   typedef enum logic {
      ST_ACCUM,
      ST_HOLD
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic signed [ACC_W-1:0]     r_acc_a;
   logic signed [ACC_W-1:0]     r_acc_b;
   logic        [CNT_W-1:0]     r_cnt;
   logic signed [out_width-1:0] r_out_a;
   logic signed [out_width-1:0] r_out_b;

   logic signed [A_XW-1:0]      w_a_ext;
   logic signed [B_XW-1:0]      w_b_ext;
   logic signed [out_width-1:0] w_a_fit;
   logic signed [out_width-1:0] w_b_fit;
   logic signed [ACC_W-1:0]     w_sum_a;
   logic signed [ACC_W-1:0]     w_sum_b;
   logic                        w_in_hs;
   logic                        w_last;

   // Sign-extend with enough headroom that the left shift never loses
   // bits before the range check / wrap.
   assign w_a_ext = {{(A_XW-a_width){in_a[a_width-1]}}, in_a};
   assign w_b_ext = {{(B_XW-b_width){in_b[b_width-1]}}, in_b};

`ifdef SVREAL_PAIR_ACCUM_SAT_EN
   localparam logic signed [out_width-1:0] MAX_CODE =
      {1'b0, {(out_width-1){1'b1}}};
   localparam logic signed [out_width-1:0] MIN_CODE =
      {1'b1, {(out_width-1){1'b0}}};

   logic signed [A_XW-1:0] w_a_sh;
   logic signed [B_XW-1:0] w_b_sh;
   logic                   w_a_ovf;
   logic                   w_b_ovf;

   assign w_a_sh = (w_a_ext <<< A_SHL) >>> A_SHR;
   assign w_b_sh = (w_b_ext <<< B_SHL) >>> B_SHR;

   // In range iff every bit above the output sign bit equals it.
   assign w_a_ovf = ~(&w_a_sh[A_XW-1:out_width-1]) &
                    (|w_a_sh[A_XW-1:out_width-1]);
   assign w_b_ovf = ~(&w_b_sh[B_XW-1:out_width-1]) &
                    (|w_b_sh[B_XW-1:out_width-1]);

   always_comb begin
      w_a_fit = w_a_sh[out_width-1:0];
      if (w_a_ovf) begin
         w_a_fit = w_a_sh[A_XW-1] ? MIN_CODE : MAX_CODE;
      end
   end

   always_comb begin
      w_b_fit = w_b_sh[out_width-1:0];
      if (w_b_ovf) begin
         w_b_fit = w_b_sh[B_XW-1] ? MIN_CODE : MAX_CODE;
      end
   end
`else
   // Wrap: only the low out_width bits of the aligned value survive.
   assign w_a_fit = out_width'((w_a_ext <<< A_SHL) >>> A_SHR);
   assign w_b_fit = out_width'((w_b_ext <<< B_SHL) >>> B_SHR);
`endif

   assign w_sum_a = r_acc_a + ACC_W'(w_a_fit);
   assign w_sum_b = r_acc_b + ACC_W'(w_b_fit);

   assign w_in_hs = in_valid & in_ready;
   assign w_last  = (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      unique case (r_state)
         ST_ACCUM: begin
            in_ready = ~rst;
            if (w_in_hs && w_last) begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = ST_ACCUM;
            end
         end
         default: w_state_nxt = ST_ACCUM;
      endcase
   end

   // The average is the accumulated sum shifted right by n_log2 (floor);
   // its low out_width bits are exactly this slice of the sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc_a <= '0;
         r_acc_b <= '0;
         r_cnt   <= '0;
         r_out_a <= '0;
         r_out_b <= '0;
      end else if (w_in_hs) begin
         if (w_last) begin
            r_out_a <= w_sum_a[ACC_W-1:n_log2];
            r_out_b <= w_sum_b[ACC_W-1:n_log2];
            r_acc_a <= '0;
            r_acc_b <= '0;
            r_cnt   <= '0;
         end else begin
            r_acc_a <= w_sum_a;
            r_acc_b <= w_sum_b;
            r_cnt   <= r_cnt + 1'b1;
         end
      end
   end

   assign out_a = r_out_a;
   assign out_b = r_out_b;

endmodule

// File: doc/svreal_pair_accum.md
# svreal_pair_accum

Decimating boxcar averager for a pair of svreal fixed-point streams. It consumes the sum/difference pair produced by the two-number add/subtract stage, `a` and `b`, each in its own width/exponent format. It averages 2^n_log2 consecutive samples of each stream and emits one averaged pair per block through a valid/ready handshake. Both results are re-expressed in a common output format.

## Interface
- `a_width`, default 18: width of `in_a`.
- `a_exponent`, default -10: exponent of `in_a` (value = code × 2^exponent).
- `b_width`, default 19: width of `in_b`.
- `b_exponent`, default -11: exponent of `in_b`.
- `out_width`, default 24: width of `out_a` and `out_b`.
- `out_exponent`, default -8: exponent shared by `out_a` and `out_b`.
- `n_log2`, default 4: block length is 2^n_log2 samples; legal range is 0..8.

- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `in_a`, input, signed `a_width`: first input sample (sum).
- `in_b`, input, signed `b_width`: second input sample (difference).
- `in_valid`, input, 1: the `in_a`/`in_b` pair is valid.
- `in_ready`, output, 1: the block accepts a pair this cycle.
- `out_a`, output, signed `out_width`: averaged `a`.
- `out_b`, output, signed `out_width`: averaged `b`.
- `out_valid`, output, 1: `out_a`/`out_b` hold a result.
- `out_ready`, input, 1: downstream accepts the result.

## Operation
- Alignment is applied per sample.
  - Shift distance is `s = in_exponent - out_exponent`.
  - `s > 0`: shift left by `s`.
  - `s < 0`: arithmetic shift right by `-s`, which truncates toward -inf.
  - `s = 0`: pass through.
  - The aligned result is then fitted to `out_width` as described under Configuration.
- Accumulators `acc_a` and `acc_b` are signed, `out_width + n_log2` bits wide, and cannot overflow.
- Sample counter is `n_log2` bits wide and counts 0..2^n_log2-1.
- State machine states:
  - **ACCUM**: `in_ready=1`. On each handshake (`in_valid & in_ready`):
    - add both aligned samples to the accumulators;
    - increment the counter.
    - On the handshake that carries count = 2^n_log2-1:
      - register `out_a = (acc_a + aligned_a) >>> n_log2` (floor); `out_b` likewise;
      - clear the accumulators and the counter;
      - go to HOLD.
  - **HOLD**: `out_valid=1`, `in_ready=0`. `out_a`/`out_b` are stable. On `out_ready=1`, go to ACCUM.
- The average result always fits in `out_width`; no final saturation is needed.
- When `n_log2=0`, every accepted sample produces an output.
- `in_valid=0` in ACCUM: state holds, and gaps between samples are allowed.
- Reset, including mid-block or while in HOLD:
  - state → ACCUM; partial sums are discarded;
  - accumulators, counter, `out_a`, `out_b` → 0;
  - `out_valid` → 0.
- `in_ready` is forced to 0 during any cycle with `rst=1`.

## Timing
- Reset values: `out_a=0`, `out_b=0`, `out_valid=0`. `in_ready=0` while `rst` is high and 1 on the first cycle after it.
- Latency: `out_valid` rises on the cycle after the final input handshake of a block.
- Output handshake completes on a cycle where `out_valid & out_ready`. `in_ready` returns to 1 on the next cycle.
- Throughput: one block per 2^n_log2 + 1 cycles at best.
- `out_valid` never drops without a handshake, except on `rst`.
- `in_ready` depends only on state and `rst`, with no combinational path from `in_valid` or `out_ready`.

## Configuration
- `SVREAL_PAIR_ACCUM_SAT_EN` defined: an aligned sample outside the signed `out_width` range clamps to the max or min code.
- `SVREAL_PAIR_ACCUM_SAT_EN` undefined: an aligned sample keeps its low `out_width` bits, i.e. wraps two's complement.
- Saturation or wrap applies only at alignment; accumulation and averaging are unchanged either way.

## Test plan
- Baseline parameters for scenarios 1-3: `a_exponent=-10`, `b_exponent=-11`, `out_exponent=-8`, `n_log2=2`.
1. Basic average: 4 pairs of `in_a=400`, `in_b=-800` → one output with `out_a=100`, `out_b=-100`, `out_valid` exactly one cycle after the 4th handshake.
2. Floor rounding: `in_b=-801` ×4 → `out_b=-101`. `in_a` aligned to 1,2,3,4 (codes 4,8,12,16) → `out_a=2`.
3. Backpressure and gaps: `in_valid` toggling with idle cycles, then `out_ready=0` for 5 cycles after the result.
   - Outputs are held constant and `in_ready=0` throughout the stall.
   - Release: one handshake, then `in_ready=1` next cycle.
4. Overflow handling with `out_width=16`, `out_exponent=-12`, `a_exponent=-10`, `n_log2=0`: `in_a=131071` → `out_a=32767` with the macro defined, `out_a=-4` without it.
5. Reset mid-block: 2 of 4 samples accepted, then `rst` pulsed, then 4 new samples of `in_a=40` → `out_a=10`, with no contribution from the pre-reset samples.
6. Reset in HOLD: assert `rst` while `out_valid=1` → next cycle `out_valid=0`, `out_a=out_b=0`, `in_ready=1`.
